// File: rtl/pattern_gen_pkg.sv
// Shared encodings and the per-pixel colour rule for the LED panel test-pattern generator.
package pattern_pkg;

  typedef enum logic [1:0] {
    FADE_R   = 2'd0,
    FADE_G   = 2'd1,
    FADE_B   = 2'd2,
    GRADIENT = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    SWAP = 2'd2
  } state_e;

  // Channels are computed at the widest supported width; callers keep the low CW bits.
  localparam int unsigned CHAN_MAX = 32;
  typedef logic [CHAN_MAX-1:0] chan_t;

  typedef struct packed {
    chan_t blue;
    chan_t green;
    chan_t red;
  } pixel_t;

  function automatic pixel_t pixel_colour(input mode_e mode, input chan_t row, input chan_t col,
                                          input chan_t level, input int unsigned row_shift,
                                          input int unsigned col_shift);
    pixel_t p;
    p = '0;
    case (mode)
      FADE_R: p.red = level;
      FADE_G: p.green = level;
      FADE_B: p.blue = level;
      default: begin
        p.red   = col << col_shift;
        p.green = level;
        p.blue  = row << row_shift;
      end
    endcase
    return p;
  endfunction

endpackage

// File: rtl/pattern_gen_button_sync.sv
// Two-flop synchroniser for an active-low push button, emitting a one-cycle pulse per press.
module button_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      prev_q <= sync_q[1];
    end
  end

  assign fall_o = prev_q & ~sync_q[1];

endmodule

// File: rtl/pattern_gen.sv
// Fills one RGB frame per animation step, one pixel per accepted write, then
// hands the frame to the display through the selected/actual buffer handshake.
module pattern_gen
  import pattern_pkg::*;
#(
  parameter int unsigned ROW_BITS = 5,
  parameter int unsigned COL_BITS = 5,
  parameter int unsigned CW       = 8,
  parameter int unsigned STEP     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         run_i,
  input  logic                         trigger_i,
  output logic [ROW_BITS+COL_BITS-1:0] wr_addr_o,
  output logic [3*CW-1:0]              wr_data_o,
  output logic                         wr_ena_o,
  input  logic                         wr_rdy_i,
  output logic                         selected_buffer_o,
  input  logic                         actual_buffer_i,
  output logic [1:0]                   mode_o,
  output logic [7:0]                   led_o
);

  localparam int unsigned AW = ROW_BITS + COL_BITS;
  localparam logic [CW-1:0] STEP_C = CW'(STEP);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [AW-1:0]     addr_q, addr_d, pix_addr;
  logic [3*CW-1:0]   data_q, data_d, pix_data;
  logic [CW-1:0]     level_q, level_d;
  logic              ena_q, ena_d, sel_q, sel_d, pend_q, pend_d;
  logic              press;
  pixel_t            pix;
  pixel_t            unused_pix;

  button_sync u_trigger_sync (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (trigger_i),
    .fall_o (press)
  );

  // The pixel after the one on the bus, or pixel 0 while the bus is still empty.
  assign pix_addr   = ena_q ? addr_q + 1'b1 : addr_q;
  assign pix        = pixel_colour(mode_q, chan_t'(pix_addr[AW-1:COL_BITS]),
                                   chan_t'(pix_addr[COL_BITS-1:0]), chan_t'(level_q),
                                   CW - ROW_BITS, CW - COL_BITS);
  assign unused_pix = pix;
  assign pix_data   = {pix.blue[CW-1:0], pix.green[CW-1:0], pix.red[CW-1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mode_q  <= GRADIENT;
      addr_q  <= '0;
      data_q  <= '0;
      level_q <= '0;
      ena_q   <= 1'b0;
      sel_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      level_q <= level_d;
      ena_q   <= ena_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    data_d  = data_q;
    level_d = level_q;
    ena_d   = ena_q;
    sel_d   = sel_q;
    pend_d  = pend_q | press;

    case (state_q)
      IDLE: begin
        if (run_i) begin
          state_d = FILL;
          addr_d  = '0;
        end
      end
      FILL: begin
        if (!ena_q) begin
          ena_d  = 1'b1;
          data_d = pix_data;
        end else if (wr_rdy_i) begin
          addr_d = pix_addr;
          data_d = pix_data;
          if (&addr_q) begin
            ena_d   = 1'b0;
            state_d = SWAP;
          end
        end
      end
      SWAP: begin
        // A press landing in the consuming cycle survives for the next frame.
        if (actual_buffer_i == sel_q) begin
          sel_d   = ~sel_q;
          level_d = level_q + STEP_C;
          if (pend_q) begin
            mode_d  = mode_e'(mode_q + 2'd1);
            level_d = '0;
            pend_d  = press;
          end
          state_d = run_i ? FILL : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_addr_o         = addr_q;
  assign wr_data_o         = data_q;
  assign wr_ena_o          = ena_q;
  assign selected_buffer_o = sel_q;
  assign mode_o            = mode_q;
  assign led_o             = 8'(level_q);

endmodule

// File: tb/tb_pattern_gen.sv
// Scoreboard bench for pattern_gen: expected pixels are queued per frame and popped as the DUT writes.
module tb_pattern_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run, trigger, rdy, actual;
  logic [9:0]  addr;
  logic [23:0] data;
  logic        ena, sel;
  logic [1:0]  mode;
  logic [7:0]  led;

  logic        w_run, w_trigger;
  logic [3:0]  w_addr;
  logic [23:0] w_data;
  logic        w_ena, w_sel;
  logic        w_actual;
  logic [1:0]  w_mode;
  logic [7:0]  w_led;

  int total = 0;
  int bad   = 0;
  logic [33:0] sb[$];

  always #5 clk = ~clk;

  pattern_gen dut (
    .clk(clk), .rst(rst), .run_i(run), .trigger_i(trigger),
    .wr_addr_o(addr), .wr_data_o(data), .wr_ena_o(ena), .wr_rdy_i(rdy),
    .selected_buffer_o(sel), .actual_buffer_i(actual), .mode_o(mode), .led_o(led)
  );

  // Small panel with STEP=255 so level wrap is reached in a few short frames.
  pattern_gen #(.ROW_BITS(2), .COL_BITS(2), .CW(8), .STEP(255)) dut_w (
    .clk(clk), .rst(rst), .run_i(w_run), .trigger_i(w_trigger),
    .wr_addr_o(w_addr), .wr_data_o(w_data), .wr_ena_o(w_ena), .wr_rdy_i(1'b1),
    .selected_buffer_o(w_sel), .actual_buffer_i(w_actual), .mode_o(w_mode), .led_o(w_led)
  );

  assign w_actual = w_sel;

  function automatic logic [23:0] model_pix(input logic [1:0] m, input logic [7:0] lvl,
                                            input logic [9:0] a);
    logic [7:0] rowc, colc;
    rowc = {a[9:5], 3'b000};
    colc = {a[4:0], 3'b000};
    case (m)
      2'd0:    return {16'h0000, lvl};
      2'd1:    return {8'h00, lvl, 8'h00};
      2'd2:    return {lvl, 16'h0000};
      default: return {rowc, lvl, colc};
    endcase
  endfunction

  task automatic push_frame(input logic [1:0] m, input logic [7:0] lvl);
    for (int i = 0; i < 1024; i++) sb.push_back({10'(i), model_pix(m, lvl, 10'(i))});
  endtask

  task automatic test_reset;
    int hi;
    rst = 1'b0; run = 1'b0; trigger = 1'b1; rdy = 1'b0; actual = 1'b0;
    w_run = 1'b0; w_trigger = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (ena !== 1'b0) begin bad++; $display("[TB] FAIL reset_ena got=%0b want=0", ena); end
    total++; if (addr !== 10'd0) begin bad++; $display("[TB] FAIL reset_addr got=%0d want=0", addr); end
    total++; if (data !== 24'd0) begin bad++; $display("[TB] FAIL reset_data got=%h want=0", data); end
    total++; if (sel !== 1'b0) begin bad++; $display("[TB] FAIL reset_sel got=%0b want=0", sel); end
    total++; if (mode !== 2'd3) begin bad++; $display("[TB] FAIL reset_mode got=%0d want=3", mode); end
    total++; if (led !== 8'd0) begin bad++; $display("[TB] FAIL reset_led got=%0d want=0", led); end
    rst = 1'b1;
    hi = 0;
    repeat (100) begin
      @(negedge clk);
      if (ena) hi++;
    end
    total++; if (hi !== 0) begin bad++; $display("[TB] FAIL idle_no_write got=%0d want=0", hi); end
  endtask

  task automatic test_wrap;
    logic [7:0] wexp[3];
    int frames;
    logic prev;
    wexp[0] = 8'd0; wexp[1] = 8'd255; wexp[2] = 8'd254;
    w_trigger = 1'b0; repeat (4) @(negedge clk);
    w_trigger = 1'b1; repeat (4) @(negedge clk);
    w_run = 1'b1;
    frames = 0; prev = 1'b0;
    for (int k = 0; k < 500 && frames < 4; k++) begin
      @(negedge clk);
      if (w_ena && !prev) begin
        frames++;
        if (frames >= 2) begin
          total++; if (w_led !== wexp[frames-2]) begin bad++; $display("[TB] FAIL wrap_level frame=%0d got=%0d want=%0d", frames, w_led, wexp[frames-2]); end
          total++; if (w_data !== {16'h0000, wexp[frames-2]}) begin bad++; $display("[TB] FAIL wrap_data frame=%0d got=%h want=%h", frames, w_data, {16'h0000, wexp[frames-2]}); end
          total++; if (w_mode !== 2'd0) begin bad++; $display("[TB] FAIL wrap_mode got=%0d want=0", w_mode); end
        end
        if (frames == 4) w_run = 1'b0;
      end
      prev = w_ena;
    end
    total++; if (frames !== 4) begin bad++; $display("[TB] FAIL wrap_frames got=%0d want=4", frames); end
    repeat (40) @(negedge clk);
  endtask

  task automatic test_full_frame;
    int acc;
    acc = 0;
    push_frame(2'd3, 8'd0);
    rdy = 1'b1; actual = 1'b0; run = 1'b1;
    for (int k = 0; k < 3000 && sb.size() > 0; k++) begin
      @(negedge clk);
      if (ena) begin
        total++; if ({addr, data} !== sb[0]) begin bad++; $display("[TB] FAIL frame_pixel got=%0d/%h want=%0d/%h", addr, data, sb[0][33:24], sb[0][23:0]); end
        if (addr == 10'd33) begin
          total++; if (data !== 24'h080008) begin bad++; $display("[TB] FAIL frame_addr33 got=%h want=080008", data); end
        end
        void'(sb.pop_front());
        acc++;
        run = 1'b0;
      end
    end
    total++; if (acc !== 1024) begin bad++; $display("[TB] FAIL frame_count got=%0d want=1024", acc); end
    @(negedge clk);
    total++; if (ena !== 1'b0) begin bad++; $display("[TB] FAIL frame_ena_drop got=%0b want=0", ena); end
    for (int k = 0; k < 20 && sel !== 1'b1; k++) @(negedge clk);
    total++; if (sel !== 1'b1) begin bad++; $display("[TB] FAIL frame_swap got=%0b want=1", sel); end
    total++; if (led !== 8'd1) begin bad++; $display("[TB] FAIL frame_level got=%0d want=1", led); end
    repeat (20) @(negedge clk);
    total++; if (ena !== 1'b0) begin bad++; $display("[TB] FAIL frame_idle got=%0b want=0", ena); end
  endtask

  task automatic test_back_pressure;
    int acc;
    acc = 0;
    sb.delete();
    push_frame(2'd3, 8'd1);
    actual = 1'b1; run = 1'b1;
    for (int k = 0; k < 6000 && sb.size() > 0; k++) begin
      @(negedge clk);
      rdy = 1'($urandom_range(0, 1));
      if (ena) begin
        total++; if ({addr, data} !== sb[0]) begin bad++; $display("[TB] FAIL bp_pixel got=%0d/%h want=%0d/%h", addr, data, sb[0][33:24], sb[0][23:0]); end
        if (rdy) begin
          void'(sb.pop_front());
          acc++;
          run = 1'b0;
        end
      end
    end
    rdy = 1'b1;
    total++; if (acc !== 1024) begin bad++; $display("[TB] FAIL bp_count got=%0d want=1024", acc); end
    for (int k = 0; k < 20 && sel !== 1'b0; k++) @(negedge clk);
    total++; if (sel !== 1'b0) begin bad++; $display("[TB] FAIL bp_swap got=%0b want=0", sel); end
    total++; if (led !== 8'd2) begin bad++; $display("[TB] FAIL bp_level got=%0d want=2", led); end
  endtask

  task automatic test_swap_handshake;
    int acc, hi;
    sb.delete();
    push_frame(2'd3, 8'd2);
    actual = 1'b1; run = 1'b1; rdy = 1'b1;
    for (int k = 0; k < 3000 && sb.size() > 0; k++) begin
      @(negedge clk);
      if (ena) begin
        total++; if ({addr, data} !== sb[0]) begin bad++; $display("[TB] FAIL swap_pixel got=%0d/%h want=%0d/%h", addr, data, sb[0][33:24], sb[0][23:0]); end
        void'(sb.pop_front());
      end
    end
    hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (ena) hi++;
    end
    total++; if (hi !== 0) begin bad++; $display("[TB] FAIL swap_wait_ena got=%0d want=0", hi); end
    total++; if (sel !== 1'b0) begin bad++; $display("[TB] FAIL swap_wait_sel got=%0b want=0", sel); end
    push_frame(2'd3, 8'd3);
    actual = 1'b0;
    @(negedge clk);
    total++; if (sel !== 1'b1) begin bad++; $display("[TB] FAIL swap_toggle got=%0b want=1", sel); end
    total++; if (ena !== 1'b0) begin bad++; $display("[TB] FAIL swap_fill_entry got=%0b want=0", ena); end
    acc = 0;
    for (int k = 0; k < 3000 && sb.size() > 0; k++) begin
      @(negedge clk);
      if (k == 0) begin
        total++; if (ena !== 1'b1) begin bad++; $display("[TB] FAIL swap_latency got=%0b want=1", ena); end
      end
      if (ena) begin
        total++; if ({addr, data} !== sb[0]) begin bad++; $display("[TB] FAIL swap_pixel2 got=%0d/%h want=%0d/%h", addr, data, sb[0][33:24], sb[0][23:0]); end
        void'(sb.pop_front());
        acc++;
        run = 1'b0;
      end
    end
    total++; if (acc !== 1024) begin bad++; $display("[TB] FAIL swap_count got=%0d want=1024", acc); end
    actual = 1'b1;
    for (int k = 0; k < 20 && sel !== 1'b0; k++) @(negedge clk);
    total++; if (led !== 8'd4) begin bad++; $display("[TB] FAIL swap_level got=%0d want=4", led); end
  endtask

  task automatic test_mode_change;
    int bad_mode;
    bad_mode = 0;
    sb.delete();
    push_frame(2'd3, 8'd4);
    push_frame(2'd0, 8'd0);
    push_frame(2'd0, 8'd1);
    run = 1'b1; rdy = 1'b1;
    for (int k = 0; k < 8000 && sb.size() > 0; k++) begin
      @(negedge clk);
      actual  = sel;
      trigger = !((k >= 100 && k < 104) || (k >= 200 && k < 204) || (k >= 300 && k < 304));
      if (sb.size() > 2048 && mode !== 2'd3) bad_mode++;
      if (sb.size() < 1024) run = 1'b0;
      if (ena) begin
        total++; if ({addr, data} !== sb[0]) begin bad++; $display("[TB] FAIL mode_pixel got=%0d/%h want=%0d/%h", addr, data, sb[0][33:24], sb[0][23:0]); end
        void'(sb.pop_front());
      end
    end
    trigger = 1'b1;
    repeat (5) begin
      @(negedge clk);
      actual = sel;
    end
    total++; if (bad_mode !== 0) begin bad++; $display("[TB] FAIL mode_midframe got=%0d want=0", bad_mode); end
    total++; if (mode !== 2'd0) begin bad++; $display("[TB] FAIL mode_after got=%0d want=0", mode); end
    total++; if (led !== 8'd2) begin bad++; $display("[TB] FAIL mode_level got=%0d want=2", led); end
  endtask

  task automatic test_reset_midframe;
    int acc;
    logic hit;
    hit = 1'b0;
    sb.delete();
    push_frame(2'd0, 8'd2);
    actual = sel; run = 1'b1; rdy = 1'b1;
    for (int k = 0; k < 2000 && !hit; k++) begin
      @(negedge clk);
      if (ena) begin
        if (addr == 10'd500) hit = 1'b1;
        else begin
          total++; if ({addr, data} !== sb[0]) begin bad++; $display("[TB] FAIL rstmid_pixel got=%0d/%h want=%0d/%h", addr, data, sb[0][33:24], sb[0][23:0]); end
          void'(sb.pop_front());
          run = 1'b0;
        end
      end
    end
    total++; if (hit !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_reach got=%0b want=1", hit); end
    rst = 1'b0;
    #1;
    total++; if (ena !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_ena got=%0b want=0", ena); end
    total++; if (addr !== 10'd0) begin bad++; $display("[TB] FAIL rstmid_addr got=%0d want=0", addr); end
    total++; if (mode !== 2'd3) begin bad++; $display("[TB] FAIL rstmid_mode got=%0d want=3", mode); end
    total++; if (led !== 8'd0) begin bad++; $display("[TB] FAIL rstmid_led got=%0d want=0", led); end
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    push_frame(2'd3, 8'd0);
    actual = 1'b0; run = 1'b1;
    acc = 0;
    for (int k = 0; k < 3000 && sb.size() > 0; k++) begin
      @(negedge clk);
      if (ena) begin
        total++; if ({addr, data} !== sb[0]) begin bad++; $display("[TB] FAIL refill_pixel got=%0d/%h want=%0d/%h", addr, data, sb[0][33:24], sb[0][23:0]); end
        void'(sb.pop_front());
        acc++;
        run = 1'b0;
      end
    end
    total++; if (acc !== 1024) begin bad++; $display("[TB] FAIL refill_count got=%0d want=1024", acc); end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_full_frame();
    test_back_pressure();
    test_swap_handshake();
    test_mode_change();
    test_reset_midframe();
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
